// File: rtl/reg_file_mp.sv
// Multi-ported integer register file with a destination-reservation scoreboard.
// Reads are combinational, with write-first bypass; writes, allocations and reset all take effect on the rising clock edge.
module reg_file_mp #(
  parameter int cXLEN    = 32,
  parameter int cRegNum  = 32,
  parameter int cRdPorts = 2,
  parameter int cWrPorts = 2
) (
  input  logic                                         iClk,
  input  logic                                         iRst,
  input  logic [cRdPorts-1:0]                          iRdDv,
  input  logic [cRdPorts-1:0][$clog2(cRegNum)-1:0]     iRdAddr,
  output logic [cRdPorts-1:0][cXLEN-1:0]               oRdData,
  output logic [cRdPorts-1:0]                          oRdBusy,
  input  logic [cWrPorts-1:0]                          iWrDv,
  input  logic [cWrPorts-1:0][$clog2(cRegNum)-1:0]     iWrAddr,
  input  logic [cWrPorts-1:0][cXLEN-1:0]               iWrData,
  input  logic                                         iAllocDv,
  input  logic [$clog2(cRegNum)-1:0]                   iAllocAddr,
  output logic [cRegNum-1:0]                           oBusyVec
);

  localparam int cAW = $clog2(cRegNum);

  logic [cRegNum-1:0][cXLEN-1:0] regs;
  logic [cRegNum-1:0]            busy;
  logic [cRegNum-1:0]            wrHit;
  logic [cRegNum-1:0]            allocHit;
  logic [cRegNum-1:0][cXLEN-1:0] wrVal;

  // Per-register write/alloc decode; ascending port scan lets the highest-index port win.
  always_comb begin
    wrHit    = '0;
    wrVal    = '0;
    allocHit = '0;
    for (int n = 1; n < cRegNum; n++) begin
      for (int w = 0; w < cWrPorts; w++) begin
        if (iWrDv[w] && (iWrAddr[w] == cAW'(n))) begin
          wrHit[n] = 1'b1;
          wrVal[n] = iWrData[w];
        end
      end
      allocHit[n] = iAllocDv && (iAllocAddr == cAW'(n));
    end
  end

  always_comb begin
    oRdData = '0;
    oRdBusy = '0;
    for (int p = 0; p < cRdPorts; p++) begin
      if (iRdDv[p] && (iRdAddr[p] != '0)) begin
        oRdData[p] = wrHit[iRdAddr[p]] ? wrVal[iRdAddr[p]] : regs[iRdAddr[p]];
        oRdBusy[p] = busy[iRdAddr[p]] & ~wrHit[iRdAddr[p]];
      end
    end
  end

  // Allocation beats a same-cycle write on the busy bit: the newer producer is still pending.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      regs <= '0;
      busy <= '0;
    end else begin
      for (int n = 1; n < cRegNum; n++) begin
        if (wrHit[n]) regs[n] <= wrVal[n];
        if (allocHit[n])   busy[n] <= 1'b1;
        else if (wrHit[n]) busy[n] <= 1'b0;
      end
    end
  end

  assign oBusyVec = busy;

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 Parameter cXLEN, default 32, data width in bits.
REQ-002 Parameter cRegNum, default 32, register count, power of two, >= 2; cAW = log2(cRegNum).
REQ-003 Parameter cRdPorts, default 2, number of read ports, 1..4.
REQ-004 Parameter cWrPorts, default 2, number of write ports, 1..4; port index cWrPorts-1 is highest priority.
REQ-005 iClk  in  1  single clock, all state updates on rising edge.
REQ-006 iRst  in  1  reset, synchronous, active-high.
REQ-007 iRdDv  in  cRdPorts  per-read-port valid.
REQ-008 iRdAddr  in  cRdPorts x cAW  per-read-port register address.
REQ-009 oRdData  out  cRdPorts x cXLEN  per-read-port data.
REQ-010 oRdBusy  out  cRdPorts  per-read-port operand-not-ready flag.
REQ-011 iWrDv  in  cWrPorts  per-write-port valid.
REQ-012 iWrAddr  in  cWrPorts x cAW  per-write-port destination address.
REQ-013 iWrData  in  cWrPorts x cXLEN  per-write-port data.
REQ-014 iAllocDv  in  1  issue-stage destination reservation valid.
REQ-015 iAllocAddr  in  cAW  reserved destination address.
REQ-016 oBusyVec  out  cRegNum  registered scoreboard, bit n = register n pending.

Function
REQ-017 Register 0 SHALL read 0 at all times; writes and allocations to address 0 SHALL be ignored, and oBusyVec[0] SHALL be 0.
REQ-018 Writes SHALL take effect at the rising edge following iWrDv=1; read ports SHALL be combinational (zero-cycle latency).
REQ-019 Two or more write ports with iWrDv=1 to the same non-zero address SHALL store only the highest-index port's data; lower ports' writes to that address are dropped.
REQ-020 Write-first bypass: read port with iRdDv=1 whose address matches a same-cycle valid write SHALL return that write's data (after REQ-019 priority), not the stored value.
REQ-021 Read port with iRdDv=0 SHALL drive oRdData=0 and oRdBusy=0.
REQ-022 Scoreboard: iAllocDv=1 SHALL set busy[iAllocAddr] at the next edge; any valid write to address n SHALL clear busy[n] at the next edge.
REQ-023 Alloc and write to same address in the same cycle: set SHALL win (busy stays 1, newer producer pending); data is still written.
REQ-024 oRdBusy[p] SHALL be busy[addr] AND NOT (same-cycle valid write to addr), i.e. a bypassed operand is ready.
REQ-025 Writes without a prior allocation SHALL update data and leave busy cleared; allocation of an already-busy register SHALL keep it busy (no counting).
REQ-026 All address inputs SHALL be fully decoded; no out-of-range condition exists given REQ-002.

Reset
REQ-027 While iRst=1 at a rising edge, all registers SHALL become 0 and all busy bits 0; writes and allocations in that cycle SHALL be discarded.
REQ-028 Reset asserted mid-operation SHALL override pending allocations; first post-reset cycle SHALL read 0 with oRdBusy=0 on every valid port.
REQ-029 Combinational outputs during reset SHALL still follow REQ-020/REQ-021 against post-clear-pending state (stored values pre-edge).

Verification
REQ-030 Reset, then read x5 on port 0 -> oRdData=0, oRdBusy=0, oBusyVec=0.
REQ-031 Write x3=0xDEADBEEF on port 0; same cycle read x3 -> 0xDEADBEEF (bypass); next cycle read x3 -> 0xDEADBEEF from storage.
REQ-032 Same cycle port 0 writes x7=0x11, port 1 writes x7=0x22 -> bypass and stored value 0x22.
REQ-033 Alloc x9; next cycle read x9 -> oRdBusy=1, oBusyVec[9]=1; write x9=0x5 while reading -> oRdBusy=0, data 0x5; following cycle oBusyVec[9]=0.
REQ-034 Same cycle alloc x4 and write x4=0xA -> oBusyVec[4]=1 next cycle, stored 0xA; write x0=0xFF and alloc x0 -> x0 reads 0, oBusyVec[0]=0.
REQ-035 Fill x1..x31 with nonzero data and alloc x12, assert iRst one cycle with concurrent write x2=0x77 -> all reads 0, oBusyVec=0 after reset.
